rx_watchdog_mc: RTL and testbench

Multi-channel successor to the single-stream receiver watchdog in the OFDM RX core. It monitors NUM_CH IQ streams plus SIGNAL-field length and equalizer output. On a false or garbage packet it aborts the receiver with a timed reset pulse, then observes a hold-off period. It sits between the sample input and the dot11 core reset, and reports the abort cause and saturating statistics for register readback.

---
 rtl/rx_watchdog_pkg.sv | 23 ++
 rtl/dc_bias_window.sv | 73 +++++++
 rtl/rx_watchdog_mc.sv | 228 ++++++++++++++++++++++
 tb/tb_rx_watchdog_mc.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_watchdog_pkg.sv
// Shared types and helpers for the multi-channel receiver watchdog.
//   wd_state_e : watchdog FSM states
//   CAUSE_*    : abort cause codes reported on abort_cause
//   sat_inc    : saturating increment, caller passes the all-ones limit
package rx_watchdog_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StPulse,
        StHoldoff
    } wd_state_e;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_LEN  = 2'd1;
    localparam logic [1:0] CAUSE_DC   = 2'd2;
    localparam logic [1:0] CAUSE_EQ   = 2'd3;

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/dc_bias_window.sv
// One channel of the DC-bias detector. Accumulates sgn(I)+sgn(Q) over a window of
// 2^DC_WIN_LOG2 accepted samples and flags when the window's |sum| exceeds th_i.
//   clock, reset  : clock, async active-high reset
//   clear_i       : synchronous clear of window counter and accumulator
//   sample_en_i   : accept iq_i this cycle
//   iq_i          : {I, Q}, signed
//   th_i          : DC threshold
//   flag_o        : combinational, high on the window-closing sample when |sum| > th_i
module dc_bias_window #(
    parameter int unsigned IQ_DATA_WIDTH = 16,
    parameter int unsigned DC_WIN_LOG2   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear_i,
    input  logic                       sample_en_i,
    input  logic [2*IQ_DATA_WIDTH-1:0] iq_i,
    input  logic [7:0]                 th_i,
    output logic                       flag_o
);

    localparam int unsigned AccW = DC_WIN_LOG2 + 2;

    logic [DC_WIN_LOG2-1:0] cnt_q, cnt_d;
    logic signed [AccW-1:0] acc_q, acc_d;
    logic signed [AccW-1:0] delta, acc_sum;
    logic [AccW-1:0]        acc_abs;
    logic                   i_neg, q_neg, last;
    logic                   unused_iq;

    // Only the sign bits matter; zero counts as positive.
    assign i_neg     = iq_i[2*IQ_DATA_WIDTH-1];
    assign q_neg     = iq_i[IQ_DATA_WIDTH-1];
    assign unused_iq = ^iq_i;

    always_comb begin
        delta = '0;
        if (!i_neg && !q_neg) begin
            delta = AccW'(2);
        end else if (i_neg && q_neg) begin
            delta = AccW'(-2);
        end
    end

    assign acc_sum = acc_q + delta;
    assign last    = (cnt_q == '1);
    // -(-2^(AccW-1)) wraps to the same pattern, which reads correctly as unsigned.
    assign acc_abs = acc_sum[AccW-1] ? AccW'(-acc_sum) : AccW'(acc_sum);
    assign flag_o  = sample_en_i && last && (32'(acc_abs) > 32'(th_i));

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (clear_i) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (sample_en_i) begin
            cnt_d = cnt_q + DC_WIN_LOG2'(1);
            acc_d = last ? '0 : acc_sum;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/rx_watchdog_mc.sv
// Multi-channel receiver watchdog. Watches SIGNAL length, per-channel DC bias and
// equalizer output; on a bad packet pulses receiver_rst for RST_PULSE_LEN cycles,
// then ignores all checks for HOLDOFF_LEN cycles. Reports last abort cause and
// saturating statistics.
// Ports: clock/reset (async active-high), enable, power_trigger, ch_mask, iq_in/iq_valid,
//   sig_valid/signal_len with min/max thresholds, dc_running_sum_th, equalizer monitor
//   controls, clear_stats; outputs receiver_rst, abort_cause, abort_count, cause_counts.
// Build option: RX_WATCHDOG_CAUSE_CNT_EN adds per-cause counters on cause_counts
//   ({eq, dc, len}); without it cause_counts is 0.
module rx_watchdog_mc import rx_watchdog_pkg::*; #(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned IQ_DATA_WIDTH = 16,
    parameter int unsigned DC_WIN_LOG2   = 4,
    parameter int unsigned EQ_SMALL_MAG  = 4,
    parameter int unsigned EQ_WIN_LEN    = 48,
    parameter int unsigned RST_PULSE_LEN = 4,
    parameter int unsigned HOLDOFF_LEN   = 64,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              power_trigger,
    input  logic [NUM_CH-1:0]                 ch_mask,
    input  logic [NUM_CH*2*IQ_DATA_WIDTH-1:0] iq_in,
    input  logic                              iq_valid,
    input  logic                              sig_valid,
    input  logic [15:0]                       signal_len,
    input  logic [3:0]                        min_signal_len_th,
    input  logic [15:0]                       max_signal_len_th,
    input  logic [7:0]                        dc_running_sum_th,
    input  logic                              equalizer_monitor_enable,
    input  logic [5:0]                        small_eq_out_counter_th,
    input  logic [31:0]                       equalizer,
    input  logic                              equalizer_valid,
    input  logic                              clear_stats,
    output logic                              receiver_rst,
    output logic [1:0]                        abort_cause,
    output logic [CNT_WIDTH-1:0]              abort_count,
    output logic [3*CNT_WIDTH-1:0]            cause_counts
);

    localparam int unsigned TimerMax = (HOLDOFF_LEN > RST_PULSE_LEN) ? HOLDOFF_LEN : RST_PULSE_LEN;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);
    localparam int unsigned EqW      = $clog2(EQ_WIN_LEN + 1);
    localparam logic [31:0] CntMax   = (CNT_WIDTH >= 32) ? 32'hFFFF_FFFF :
                                       ((32'd1 << CNT_WIDTH) - 32'd1);

    wd_state_e             state_q, state_d;
    logic [TimerW-1:0]     timer_q, timer_d;
    logic                  rst_q;
    logic [1:0]            cause_q, next_cause;
    logic [CNT_WIDTH-1:0]  abort_cnt_q, abort_cnt_d;
    logic                  checks_on, enter_pulse;

    // Checks run only while armed and enabled; everything else holds accumulators at 0.
    assign checks_on = (state_q == StArmed) && enable;

    // DC bias: abort only when every masked channel flags on the same window.
    logic [NUM_CH-1:0] dc_flag;
    logic              dc_abort;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_dc
        dc_bias_window #(
            .IQ_DATA_WIDTH (IQ_DATA_WIDTH),
            .DC_WIN_LOG2   (DC_WIN_LOG2)
        ) u_dc (
            .clock       (clock),
            .reset       (reset),
            .clear_i     (!checks_on),
            .sample_en_i (checks_on && power_trigger && ch_mask[k] && iq_valid),
            .iq_i        (iq_in[k*2*IQ_DATA_WIDTH +: 2*IQ_DATA_WIDTH]),
            .th_i        (dc_running_sum_th),
            .flag_o      (dc_flag[k])
        );
    end

    assign dc_abort = (|ch_mask) && ((dc_flag | ~ch_mask) == '1);

    // Length check.
    logic len_abort;
    assign len_abort = checks_on && sig_valid &&
                       ((signal_len < {12'd0, min_signal_len_th}) ||
                        (signal_len > max_signal_len_th));

    // Equalizer small-output check.
    logic [16:0]    eq_i_abs, eq_q_abs;
    logic           eq_small, eq_sample, eq_abort;
    logic [EqW-1:0] small_cnt_q, small_cnt_d, pos_cnt_q, pos_cnt_d, small_next;

    // 17-bit magnitude so -32768 does not wrap.
    assign eq_i_abs  = equalizer[31] ? (17'd0 - {1'b1, equalizer[31:16]}) : {1'b0, equalizer[31:16]};
    assign eq_q_abs  = equalizer[15] ? (17'd0 - {1'b1, equalizer[15:0]}) : {1'b0, equalizer[15:0]};
    assign eq_small  = (eq_i_abs < 17'(EQ_SMALL_MAG)) && (eq_q_abs < 17'(EQ_SMALL_MAG));
    assign eq_sample = checks_on && equalizer_monitor_enable && equalizer_valid;
    assign small_next = small_cnt_q + EqW'(eq_small);
    assign eq_abort  = eq_sample && eq_small && (small_eq_out_counter_th != 6'd0) &&
                       (32'(small_next) >= 32'(small_eq_out_counter_th));

    always_comb begin
        small_cnt_d = small_cnt_q;
        pos_cnt_d   = pos_cnt_q;
        if (!checks_on || sig_valid) begin
            small_cnt_d = '0;
            pos_cnt_d   = '0;
        end else if (eq_sample) begin
            if (pos_cnt_q == EqW'(EQ_WIN_LEN - 1)) begin
                small_cnt_d = '0;
                pos_cnt_d   = '0;
            end else begin
                small_cnt_d = small_next;
                pos_cnt_d   = pos_cnt_q + EqW'(1);
            end
        end
    end

    // Cause priority: length > DC > equalizer.
    always_comb begin
        next_cause = CAUSE_NONE;
        if (len_abort) begin
            next_cause = CAUSE_LEN;
        end else if (dc_abort) begin
            next_cause = CAUSE_DC;
        end else if (eq_abort) begin
            next_cause = CAUSE_EQ;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        enter_pulse = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StArmed;
            end
            StArmed: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (next_cause != CAUSE_NONE) begin
                    state_d     = StPulse;
                    timer_d     = '0;
                    enter_pulse = 1'b1;
                end
            end
            StPulse: begin
                if (timer_q == TimerW'(RST_PULSE_LEN - 1)) begin
                    state_d = StHoldoff;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StHoldoff: begin
                if (timer_q == TimerW'(HOLDOFF_LEN - 1)) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        abort_cnt_d = abort_cnt_q;
        if (clear_stats) begin
            abort_cnt_d = '0;
        end else if (enter_pulse) begin
            abort_cnt_d = CNT_WIDTH'(sat_inc(32'(abort_cnt_q), CntMax));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            rst_q       <= 1'b0;
            cause_q     <= CAUSE_NONE;
            abort_cnt_q <= '0;
            small_cnt_q <= '0;
            pos_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            rst_q       <= (state_d == StPulse);
            if (enter_pulse) cause_q <= next_cause;
            abort_cnt_q <= abort_cnt_d;
            small_cnt_q <= small_cnt_d;
            pos_cnt_q   <= pos_cnt_d;
        end
    end

    assign receiver_rst = rst_q;
    assign abort_cause  = cause_q;
    assign abort_count  = abort_cnt_q;

`ifdef RX_WATCHDOG_CAUSE_CNT_EN
    // Index 0 = len, 1 = dc, 2 = eq.
    logic [CNT_WIDTH-1:0] cc_q [3];
    logic [CNT_WIDTH-1:0] cc_d [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cc_d[i] = cc_q[i];
            if (clear_stats) begin
                cc_d[i] = '0;
            end else if (enter_pulse && (next_cause == 2'(i + 1))) begin
                cc_d[i] = CNT_WIDTH'(sat_inc(32'(cc_q[i]), CntMax));
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) cc_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) cc_q[i] <= cc_d[i];
        end
    end

    assign cause_counts = {cc_q[2], cc_q[1], cc_q[0]};
`else
    assign cause_counts = '0;
`endif

endmodule

// File: tb/tb_rx_watchdog_mc.sv
// Directed bench for rx_watchdog_mc, built with a 4-bit statistics width so that
// counter saturation is reachable in a short run.
module tb_rx_watchdog_mc;
    import rx_watchdog_pkg::*;

    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = '1;

    logic            clock = 1'b0;
    logic            reset;
    logic            enable, power_trigger, iq_valid, sig_valid;
    logic [1:0]      ch_mask;
    logic [63:0]     iq_in;
    logic [15:0]     signal_len, max_signal_len_th;
    logic [3:0]      min_signal_len_th;
    logic [7:0]      dc_running_sum_th;
    logic            equalizer_monitor_enable, equalizer_valid, clear_stats;
    logic [5:0]      small_eq_out_counter_th;
    logic [31:0]     equalizer;
    logic            receiver_rst;
    logic [1:0]      abort_cause;
    logic [CW-1:0]   abort_count;
    logic [3*CW-1:0] cause_counts;

    int total = 0;
    int bad   = 0;
    logic [CW-1:0] exp_cnt;
    logic [CW-1:0] exp_cc [3];

    rx_watchdog_mc #(.CNT_WIDTH(CW)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .enable                   (enable),
        .power_trigger            (power_trigger),
        .ch_mask                  (ch_mask),
        .iq_in                    (iq_in),
        .iq_valid                 (iq_valid),
        .sig_valid                (sig_valid),
        .signal_len               (signal_len),
        .min_signal_len_th        (min_signal_len_th),
        .max_signal_len_th        (max_signal_len_th),
        .dc_running_sum_th        (dc_running_sum_th),
        .equalizer_monitor_enable (equalizer_monitor_enable),
        .small_eq_out_counter_th  (small_eq_out_counter_th),
        .equalizer                (equalizer),
        .equalizer_valid          (equalizer_valid),
        .clear_stats              (clear_stats),
        .receiver_rst             (receiver_rst),
        .abort_cause              (abort_cause),
        .abort_count              (abort_count),
        .cause_counts             (cause_counts)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [15:0] len;
        logic [3:0]  mn;
        logic [15:0] mx;
        logic        ab;
    } len_vec_t;

    typedef struct {
        logic       pt;
        logic [1:0] mask;
        int         k0;
        int         k1;
        logic [7:0] th;
        logic       ab;
    } dc_vec_t;

    typedef struct {
        logic       en;
        logic [5:0] th;
        int         kind;
        int         n;
        int         first;
    } eq_vec_t;

    len_vec_t lv [7];
    dc_vec_t  dv [10];
    eq_vec_t  ev [7];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic note_abort(input logic [1:0] c);
        exp_cnt = (exp_cnt == CMAX) ? CMAX : exp_cnt + 1'b1;
        exp_cc[c-1] = (exp_cc[c-1] == CMAX) ? CMAX : exp_cc[c-1] + 1'b1;
    endtask

    task automatic check_stats(input string name);
        logic [3*CW-1:0] want;
`ifdef RX_WATCHDOG_CAUSE_CNT_EN
        want = {exp_cc[2], exp_cc[1], exp_cc[0]};
`else
        want = '0;
`endif
        check({name, " abort_count"}, 32'(abort_count), 32'(exp_cnt));
        check({name, " cause_counts"}, 32'(cause_counts), 32'(want));
    endtask

    // Call right after the tick whose edge sampled the abort condition.
    task automatic pulse_check(input string name, input logic [1:0] cause);
        int n;
        n = 0;
        check({name, " rst"}, 32'(receiver_rst), 32'd1);
        check({name, " cause"}, 32'(abort_cause), 32'(cause));
        note_abort(cause);
        check_stats(name);
        for (int i = 0; i < 8; i++) begin
            if (receiver_rst) n++;
            tick();
        end
        check({name, " pulse len"}, 32'(n), 32'd4);
    endtask

    task automatic recover;
        repeat (64) tick();
    endtask

    task automatic len_abort_now(input string name);
        signal_len = 16'd5;
        min_signal_len_th = 4'd14;
        sig_valid = 1'b1;
        tick();
        sig_valid = 1'b0;
        pulse_check(name, CAUSE_LEN);
        recover();
        min_signal_len_th = 4'd0;
    endtask

    function automatic logic [31:0] dc_sample(input int kind, input int idx);
        case (kind)
            0: return 32'h03E8_03E8;
            1: return (idx % 2 == 0) ? 32'h03E8_03E8 : 32'hFC18_FC18;
            2: return $urandom;
            3: return (idx < 5) ? 32'h03E8_03E8 : 32'h03E8_FC18;
            4: return 32'hFC18_FC18;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] eq_sample(input int kind, input int idx);
        logic [31:0] sm, bg;
        sm = (idx % 2 == 0) ? 32'h0001_0001 : 32'h0003_FFFD;
        bg = (idx % 2 == 0) ? 32'h0004_0000 : 32'h0000_FFFC;
        case (kind)
            0: return (idx % 4 == 3 && idx < 40) ? sm : bg;
            1: return sm;
            2: return (idx % 48 >= 41) ? sm : bg;
            default: return bg;
        endcase
    endfunction

    initial begin
        int first, hits;
        string nm;

        lv[0] = '{16'd5,    4'd14, 16'd1000, 1'b1};
        lv[1] = '{16'd14,   4'd14, 16'd1000, 1'b0};
        lv[2] = '{16'd13,   4'd14, 16'd1000, 1'b1};
        lv[3] = '{16'd1000, 4'd14, 16'd1000, 1'b0};
        lv[4] = '{16'd1001, 4'd14, 16'd1000, 1'b1};
        lv[5] = '{16'd0,    4'd0,  16'd0,    1'b0};
        lv[6] = '{16'd4095, 4'd15, 16'd4095, 1'b0};

        dv[0] = '{1'b1, 2'b11, 0, 0, 8'd10, 1'b1};
        dv[1] = '{1'b1, 2'b11, 0, 1, 8'd10, 1'b0};
        dv[2] = '{1'b1, 2'b01, 0, 2, 8'd10, 1'b1};
        dv[3] = '{1'b1, 2'b00, 0, 0, 8'd10, 1'b0};
        dv[4] = '{1'b1, 2'b11, 3, 3, 8'd10, 1'b0};
        dv[5] = '{1'b1, 2'b11, 3, 3, 8'd9,  1'b1};
        dv[6] = '{1'b1, 2'b11, 4, 5, 8'd10, 1'b1};
        dv[7] = '{1'b1, 2'b10, 2, 4, 8'd31, 1'b1};
        dv[8] = '{1'b1, 2'b11, 0, 0, 8'd32, 1'b0};
        dv[9] = '{1'b0, 2'b11, 0, 0, 8'd10, 1'b0};

        ev[0] = '{1'b1, 6'd8, 0, 48, 31};
        ev[1] = '{1'b1, 6'd0, 1, 48, -1};
        ev[2] = '{1'b1, 6'd8, 2, 96, -1};
        ev[3] = '{1'b1, 6'd1, 1, 48, 0};
        ev[4] = '{1'b1, 6'd1, 4, 48, -1};
        ev[5] = '{1'b0, 6'd1, 1, 48, -1};
        ev[6] = '{1'b1, 6'd7, 2, 96, 47};

        exp_cnt = '0;
        for (int i = 0; i < 3; i++) exp_cc[i] = '0;

        reset = 1'b1;
        enable = 1'b0; power_trigger = 1'b0; ch_mask = 2'b00; iq_in = '0; iq_valid = 1'b0;
        sig_valid = 1'b0; signal_len = 16'd100; min_signal_len_th = 4'd0;
        max_signal_len_th = 16'hFFFF; dc_running_sum_th = 8'd10;
        equalizer_monitor_enable = 1'b0; small_eq_out_counter_th = 6'd0;
        equalizer = '0; equalizer_valid = 1'b0; clear_stats = 1'b0;

        #12;
        check("reset rst", 32'(receiver_rst), 32'd0);
        check("reset cause", 32'(abort_cause), 32'(CAUSE_NONE));
        check_stats("reset");
        #10 reset = 1'b0;
        tick();
        enable = 1'b1;
        tick();

        // Length check table.
        for (int i = 0; i < 7; i++) begin
            nm = $sformatf("len%0d", i);
            signal_len = lv[i].len;
            min_signal_len_th = lv[i].mn;
            max_signal_len_th = lv[i].mx;
            sig_valid = 1'b1;
            tick();
            sig_valid = 1'b0;
            if (lv[i].ab) begin
                pulse_check(nm, CAUSE_LEN);
                recover();
            end else begin
                check({nm, " no abort"}, 32'(receiver_rst), 32'd0);
            end
        end
        min_signal_len_th = 4'd0;
        max_signal_len_th = 16'hFFFF;

        // DC bias table.
        for (int i = 0; i < 10; i++) begin
            nm = $sformatf("dc%0d", i);
            power_trigger = dv[i].pt;
            ch_mask = dv[i].mask;
            dc_running_sum_th = dv[i].th;
            for (int s = 0; s < 16; s++) begin
                iq_in = {dc_sample(dv[i].k1, s), dc_sample(dv[i].k0, s)};
                iq_valid = 1'b1;
                tick();
            end
            iq_valid = 1'b0;
            if (dv[i].ab) begin
                pulse_check(nm, CAUSE_DC);
                recover();
            end else begin
                check({nm, " no abort"}, 32'(receiver_rst), 32'd0);
            end
        end
        power_trigger = 1'b0;

        // Equalizer table; a good SIGNAL first restarts the window.
        for (int i = 0; i < 7; i++) begin
            nm = $sformatf("eq%0d", i);
            signal_len = 16'd100;
            sig_valid = 1'b1;
            tick();
            sig_valid = 1'b0;
            equalizer_monitor_enable = ev[i].en;
            small_eq_out_counter_th = ev[i].th;
            first = -1;
            for (int s = 0; s < ev[i].n; s++) begin
                equalizer = eq_sample(ev[i].kind, s);
                equalizer_valid = 1'b1;
                tick();
                if (receiver_rst && first < 0) first = s;
            end
            equalizer_valid = 1'b0;
            check({nm, " abort index"}, 32'(first), 32'(ev[i].first));
            if (ev[i].first >= 0) begin
                check({nm, " cause"}, 32'(abort_cause), 32'(CAUSE_EQ));
                note_abort(CAUSE_EQ);
                check_stats(nm);
            end
            recover();
        end
        equalizer_monitor_enable = 1'b0;

        // Length and DC in the same cycle: one abort, length wins.
        power_trigger = 1'b1;
        ch_mask = 2'b11;
        dc_running_sum_th = 8'd10;
        min_signal_len_th = 4'd14;
        signal_len = 16'd5;
        for (int s = 0; s < 16; s++) begin
            iq_in = {dc_sample(0, s), dc_sample(0, s)};
            iq_valid = 1'b1;
            sig_valid = (s == 15);
            tick();
        end
        iq_valid = 1'b0;
        sig_valid = 1'b0;
        pulse_check("simul", CAUSE_LEN);

        // Every kind of abort stimulus during holdoff must be ignored.
        equalizer_monitor_enable = 1'b1;
        small_eq_out_counter_th = 6'd1;
        hits = 0;
        for (int s = 0; s < 40; s++) begin
            iq_in = {dc_sample(0, s), dc_sample(0, s)};
            iq_valid = 1'b1;
            sig_valid = 1'b1;
            equalizer = eq_sample(1, s);
            equalizer_valid = 1'b1;
            tick();
            if (receiver_rst) hits++;
        end
        iq_valid = 1'b0; sig_valid = 1'b0; equalizer_valid = 1'b0;
        equalizer_monitor_enable = 1'b0; power_trigger = 1'b0;
        min_signal_len_th = 4'd0;
        check("holdoff rst cycles", 32'(hits), 32'd0);
        check_stats("holdoff");
        recover();

        // Drive the counter to all-ones, then one more abort must hold it there.
        for (int i = 0; i < 20 && exp_cnt != CMAX; i++) len_abort_now($sformatf("fill%0d", i));
        len_abort_now("saturate");

        // clear_stats beats the increment of a coincident abort.
        min_signal_len_th = 4'd14;
        signal_len = 16'd5;
        sig_valid = 1'b1;
        clear_stats = 1'b1;
        tick();
        sig_valid = 1'b0;
        clear_stats = 1'b0;
        exp_cnt = '0;
        for (int i = 0; i < 3; i++) exp_cc[i] = '0;
        check("clear rst", 32'(receiver_rst), 32'd1);
        check("clear cause", 32'(abort_cause), 32'(CAUSE_LEN));
        check_stats("clear");
        repeat (8) tick();
        recover();

        // Asynchronous reset in the middle of a pulse.
        sig_valid = 1'b1;
        tick();
        sig_valid = 1'b0;
        check("midpulse rst before", 32'(receiver_rst), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midpulse rst after", 32'(receiver_rst), 32'd0);
        check("midpulse state", 32'(dut.state_q), 32'(StIdle));
        check("midpulse cause", 32'(abort_cause), 32'(CAUSE_NONE));
        exp_cnt = '0;
        check_stats("midpulse");
        #2 reset = 1'b0;
        tick();
        len_abort_now("after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
